interrupt_arbiter: RTL and testbench
====================================

# interrupt_arbiter

Sequencing interrupt controller between the peripheral interrupt flags and the PicoBlaze `interrupt`/`interrupt_ack` pins. It latches source events into pending bits, masks them with the enable word from an output port, and selects the highest-priority enabled source. It drives a single interrupt request held until the processor acknowledges, then blocks further requests until the ISR signals completion. Source ID and pending status are readable through input ports.

## Interface
- `N_SRC`, 8, number of interrupt sources; bit 0 is highest priority
- `ID_W`, 3, width of source ID; ceil(log2(N_SRC))

- `clk` input 1: single clock, all logic rising-edge
- `reset` input 1: synchronous, active-high
- `int_config_port` input N_SRC: enable mask, from an output port, 1 = enabled
- `int_flags` input N_SRC: raw source flags, synchronous to `clk`
- `int_clear_port` input N_SRC: write-1-to-clear pending bits, qualified by `int_clear_strobe`
- `int_clear_strobe` input 1: one-cycle write strobe for `int_clear_port`
- `int_done` input 1: one-cycle strobe from the ISR (output-port write) marking end of service
- `interrupt_ack` input 1: PicoBlaze acknowledge
- `int_out` output 1: interrupt request to PicoBlaze
- `int_id` output ID_W: ID of the source being serviced
- `int_pending` output N_SRC: raw pending bits, unmasked
- `int_busy` output 1: high in ASSERT and SERVICE

## Operation
- Pending set: bit i sets on an event on `int_flags[i]`. The event is a rising edge or a level, per Configuration.
- Pending clear:
  - on `interrupt_ack` in ASSERT, the bit `int_id` clears;
  - on `int_clear_strobe`, every bit set in `int_clear_port` clears.
  - A set event and a clear in the same cycle: set wins.
- Requests = `int_pending & int_config_port`. The winner is the lowest set index, from a combinational priority encoder.
- FSM, 3 states:
  - IDLE: `int_out`=0. If requests ≠ 0, latch the winner into `int_id` and go to ASSERT.
  - ASSERT: `int_out`=1 and `int_id` frozen. Enable-mask changes and clears of the active bit do not deassert `int_out`. On `interrupt_ack`, clear the pending bit and go to SERVICE.
  - SERVICE: `int_out`=0. New events still latch into pending. On `int_done`, go to IDLE.
- `interrupt_ack` outside ASSERT and `int_done` outside SERVICE are ignored.
- Reset values: all outputs 0, pending 0, edge history 0, state IDLE. Reset mid-operation drops `int_out` on the next edge and discards all pending bits.

## Timing
- `int_flags` goes high at cycle N, sampled at edge N → pending visible at N+1 → `int_out` high at N+2. Two-cycle latency from IDLE.
- `interrupt_ack` sampled high at edge M → `int_out` low at M+1 and pending bit clear at M+1.
- `int_done` at edge K → IDLE at K+1. The earliest following `int_out` is at K+2.
- `int_out` is registered and glitch-free. It holds at least one cycle and stays high until ack.
- `int_id` changes only on the IDLE→ASSERT transition.
- `int_pending` is the registered pending vector, no extra latency.
- A flag held high across service does not re-trigger in edge mode.

## Configuration
- `INTERRUPT_ARBITER_EDGE_EN` defined:
  - pending bit sets on a 0→1 transition of `int_flags[i]` between consecutive clocks;
  - an edge history register of N_SRC bits is present.
- Undefined:
  - pending bit sets on every cycle `int_flags[i]`=1 (level-sensitive);
  - no history register;
  - the source must drop its flag before `int_done`, or it re-requests.

## Structure
- Shared include `interrupt_defs.v`, with an `ifndef` guard, holds the FSM state encodings `INT_ST_IDLE`=2'd0, `INT_ST_ASSERT`=2'd1, `INT_ST_SERVICE`=2'd2, plus the default `N_SRC` and `ID_W`.
- Sub-module `int_priority_encoder`: N_SRC-bit request in → `ID_W` index plus `valid` out, combinational, lowest index wins.

## Test plan
- Edge mode, mask 8'hFF: pulse `int_flags[3]` → `int_out`=1 two cycles later, `int_id`=3. Ack → `int_out`=0 next cycle, `int_pending`=0.
- Flags 8'b0010_0100 set in the same cycle → service ID 2 first. After ack and `int_done`, ID 5 is serviced with `int_out` reasserting two cycles after `int_done`.
- Mask 8'h00 with `int_flags[1]` pulsed → `int_pending`=8'h02 and `int_out` stays 0. Set mask 8'h02 → `int_out`=1 one cycle later.
- In SERVICE, strobe `int_clear_port`=8'h10 in the same cycle as a new rising edge on flag 4 → bit 4 stays pending (set wins).
- Assert `reset` while in ASSERT with pending 8'h81 → next cycle `int_out`=0, `int_id`=0, `int_pending`=0, state IDLE.
- Level mode (macro undefined): hold `int_flags[0]`=1 through ack and `int_done` → `int_out` reasserts two cycles after `int_done`.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// Shared types for the interrupt arbiter: FSM state encodings and default sizing.
package interrupt_arbiter_pkg;

    localparam int INT_N_SRC_DEFAULT = 8;
    localparam int INT_ID_W_DEFAULT  = 3;

    typedef enum logic [1:0] {
        INT_ST_IDLE    = 2'd0,
        INT_ST_ASSERT  = 2'd1,
        INT_ST_SERVICE = 2'd2
    } int_state_e;

endpackage

// File: rtl/interrupt_arbiter_prio_enc.sv
// Combinational priority encoder for the interrupt arbiter; the lowest set index wins.
module int_priority_encoder
    import interrupt_arbiter_pkg::*;
#(
    parameter int N_SRC = INT_N_SRC_DEFAULT,
    parameter int ID_W  = INT_ID_W_DEFAULT
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Scan downward so the last match, the lowest index, is the one kept.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// PicoBlaze interrupt arbiter: pending latch, enable mask, priority select, request/ack/done sequencing.
// Define INTERRUPT_ARBITER_EDGE_EN for rising-edge source detection; the default build is level-sensitive.
//
// state          | meaning
// INT_ST_IDLE    | no request out; waits for any enabled pending source
// INT_ST_ASSERT  | int_out high, int_id frozen; waits for interrupt_ack
// INT_ST_SERVICE | ISR running; new events still latch; waits for int_done
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int N_SRC = INT_N_SRC_DEFAULT,
    parameter int ID_W  = INT_ID_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] int_config_port,
    input  logic [N_SRC-1:0] int_flags,
    input  logic [N_SRC-1:0] int_clear_port,
    input  logic             int_clear_strobe,
    input  logic             int_done,
    input  logic             interrupt_ack,
    output logic             int_out,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] int_pending,
    output logic             int_busy
);

    int_state_e       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic             int_out_q, int_out_d;

    logic [N_SRC-1:0] set_ev;
    logic [N_SRC-1:0] clr_mask;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] requests;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic             ack_take;

`ifdef INTERRUPT_ARBITER_EDGE_EN
    logic [N_SRC-1:0] hist_q, hist_d;

    assign hist_d = int_flags;
    assign set_ev = int_flags & ~hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign set_ev = int_flags;
`endif

    assign requests = pending_q & int_config_port;

    int_priority_encoder #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .req   (requests),
        .id    (win_id),
        .valid (win_valid)
    );

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_mask[i] = (int_id_q == ID_W'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_take = 1'b0;
        case (state_q)
            INT_ST_IDLE: begin
                if (win_valid) begin
                    state_d  = INT_ST_ASSERT;
                    int_id_d = win_id;
                end
            end
            INT_ST_ASSERT: begin
                if (interrupt_ack) begin
                    ack_take = 1'b1;
                    state_d  = INT_ST_SERVICE;
                end
            end
            INT_ST_SERVICE: begin
                if (int_done) begin
                    state_d = INT_ST_IDLE;
                end
            end
            default: state_d = INT_ST_IDLE;
        endcase
        int_out_d = (state_d == INT_ST_ASSERT);
    end

    // A same-cycle set event overrides either clear source.
    always_comb begin
        clr_mask = '0;
        if (ack_take) begin
            clr_mask = clr_mask | ack_mask;
        end
        if (int_clear_strobe) begin
            clr_mask = clr_mask | int_clear_port;
        end
        pending_d = (pending_q & ~clr_mask) | set_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INT_ST_IDLE;
            pending_q <= '0;
            int_id_q  <= '0;
            int_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            int_id_q  <= int_id_d;
            int_out_q <= int_out_d;
        end
    end

    assign int_out     = int_out_q;
    assign int_id      = int_id_q;
    assign int_pending = pending_q;
    assign int_busy    = (state_q != INT_ST_IDLE);

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_interrupt_arbiter;

`ifdef INTERRUPT_ARBITER_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] int_config_port;
    logic [7:0] int_flags;
    logic [7:0] int_clear_port;
    logic       int_clear_strobe;
    logic       int_done;
    logic       interrupt_ack;
    logic       int_out;
    logic [2:0] int_id;
    logic [7:0] int_pending;
    logic       int_busy;

    int n_total = 0;
    int n_bad   = 0;

    // reference model
    logic [7:0] m_pend;
    logic [7:0] m_prev;
    logic       m_req;
    logic       m_svc;
    logic [2:0] m_id;

    interrupt_arbiter #(.N_SRC(8), .ID_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .int_config_port  (int_config_port),
        .int_flags        (int_flags),
        .int_clear_port   (int_clear_port),
        .int_clear_strobe (int_clear_strobe),
        .int_done         (int_done),
        .interrupt_ack    (interrupt_ack),
        .int_out          (int_out),
        .int_id           (int_id),
        .int_pending      (int_pending),
        .int_busy         (int_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [7:0] lb;
        lb = v & (~v + 8'd1);
        return 3'($countones(lb - 8'd1));
    endfunction

    task automatic model_update();
        logic [7:0] ev;
        logic [7:0] clr;
        logic [7:0] req;
        ev  = EDGE_MODE ? (int_flags & ~m_prev) : int_flags;
        clr = int_clear_strobe ? int_clear_port : 8'h00;
        if (reset) begin
            m_pend = 8'h00;
            m_prev = 8'h00;
            m_req  = 1'b0;
            m_svc  = 1'b0;
            m_id   = 3'd0;
        end else begin
            req = m_pend & int_config_port;
            if (!m_req && !m_svc) begin
                if (req != 8'h00) begin
                    m_id  = lowest_idx(req);
                    m_req = 1'b1;
                end
            end else if (m_req) begin
                if (interrupt_ack) begin
                    clr   = clr | (8'h01 << m_id);
                    m_req = 1'b0;
                    m_svc = 1'b1;
                end
            end else if (int_done) begin
                m_svc = 1'b0;
            end
            m_pend = (m_pend & ~clr) | ev;
            m_prev = int_flags;
        end
    endtask

    // One clock: model follows the inputs seen at the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("out",  32'(int_out),     32'(m_req));
        chk("id",   32'(int_id),      32'(m_id));
        chk("pend", 32'(int_pending), 32'(m_pend));
        chk("busy", 32'(int_busy),    32'(m_req | m_svc));
    endtask

    task automatic quiet();
        reset            = 1'b0;
        int_flags        = 8'h00;
        int_clear_port   = 8'h00;
        int_clear_strobe = 1'b0;
        int_done         = 1'b0;
        interrupt_ack    = 1'b0;
    endtask

    task automatic ack_then_done();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        int_done = 1'b1;
        step();
        int_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pend = 8'h00; m_prev = 8'h00; m_req = 1'b0; m_svc = 1'b0; m_id = 3'd0;
        quiet();
        int_config_port = 8'hFF;
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        chk("rst_pend", 32'(int_pending), 32'h00);
        chk("rst_out",  32'(int_out), 32'h0);

        // single source, two-cycle latency, ack clears
        int_flags = 8'h08;
        step();
        int_flags = 8'h00;
        chk("s1_pend", 32'(int_pending), 32'h08);
        step();
        chk("s1_out", 32'(int_out), 32'h1);
        chk("s1_id",  32'(int_id),  32'h3);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        chk("s1_ack_out",  32'(int_out), 32'h0);
        chk("s1_ack_pend", 32'(int_pending), 32'h00);
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();

        // two sources together: 2 first, 5 two cycles after done
        int_flags = 8'h24;
        step();
        int_flags = 8'h00;
        step();
        chk("s2_id_a", 32'(int_id), 32'h2);
        ack_then_done();
        chk("s2_gap_out", 32'(int_out), 32'h0);
        step();
        chk("s2_out_b", 32'(int_out), 32'h1);
        chk("s2_id_b",  32'(int_id),  32'h5);
        ack_then_done();
        step();

        // masked source stays pending until enabled
        int_config_port = 8'h00;
        int_flags = 8'h02;
        step();
        int_flags = 8'h00;
        step();
        step();
        chk("s3_pend", 32'(int_pending), 32'h02);
        chk("s3_out",  32'(int_out), 32'h0);
        int_config_port = 8'h02;
        step();
        chk("s3_out_en", 32'(int_out), 32'h1);
        chk("s3_id",     32'(int_id),  32'h1);
        int_config_port = 8'hFF;
        ack_then_done();
        step();

        // set beats clear inside SERVICE
        int_flags = 8'h10;
        step();
        int_flags = 8'h00;
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        int_flags = 8'h10;
        int_clear_port = 8'h10;
        int_clear_strobe = 1'b1;
        step();
        quiet();
        chk("s4_set_wins", 32'(int_pending[4]), 32'h1);
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        ack_then_done();
        step();

        // reset while asserting
        int_flags = 8'h81;
        step();
        int_flags = 8'h00;
        step();
        chk("s5_pre_out", 32'(int_out), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s5_out",  32'(int_out), 32'h0);
        chk("s5_id",   32'(int_id),  32'h0);
        chk("s5_pend", 32'(int_pending), 32'h00);
        chk("s5_busy", 32'(int_busy), 32'h0);

        // flag held through ack and done
        int_flags = 8'h01;
        step();
        step();
        ack_then_done();
        step();
        chk("s6_reassert", 32'(int_out), EDGE_MODE ? 32'h0 : 32'h1);
        int_flags = 8'h00;
        step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        step();

        // random traffic, including stray acks/dones and occasional resets
        for (int c = 0; c < 2000; c++) begin
            int_flags        = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            if ($urandom_range(0, 9) == 0) int_config_port = 8'($urandom);
            int_clear_strobe = ($urandom_range(0, 7) == 0);
            int_clear_port   = 8'($urandom);
            interrupt_ack    = ($urandom_range(0, 2) == 0);
            int_done         = ($urandom_range(0, 3) == 0);
            reset            = ($urandom_range(0, 149) == 0);
            step();
        end
        quiet();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
